// File: rtl/audio_seq_ctrl_if.sv
// Signal bundle between the record/playback sequencer and its surroundings:
// user controls, microphone front end, sample RAM port, PWM duty port and status.
//   master : the sequencer (drives mic_en, RAM address/strobes, PWM duty, status)
//   slave  : the environment (drives controls, mic samples, RAM read data)
interface audio_seq_ctrl_if #(
    parameter int ADDR_W   = 10,
    parameter int SAMPLE_W = 8,
    parameter int DUTY_W   = 6
);
    logic                rec_start;
    logic                play_start;
    logic                stop;
    logic                loop_en;
    logic                mic_en;
    logic                mic_valid;
    logic [SAMPLE_W-1:0] mic_data;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_we;
    logic [SAMPLE_W-1:0] mem_wdata;
    logic                mem_re;
    logic [SAMPLE_W-1:0] mem_rdata;
    logic [DUTY_W-1:0]   pwm_duty;
    logic                pwm_load;
    logic [ADDR_W:0]     rec_len;
    logic                busy;
    logic                done;
    logic [1:0]          state_dbg;

    modport master (
        input  rec_start, play_start, stop, loop_en, mic_valid, mic_data, mem_rdata,
        output mic_en, mem_addr, mem_we, mem_wdata, mem_re, pwm_duty, pwm_load,
               rec_len, busy, done, state_dbg
    );

    modport slave (
        output rec_start, play_start, stop, loop_en, mic_valid, mic_data, mem_rdata,
        input  mic_en, mem_addr, mem_we, mem_wdata, mem_re, pwm_duty, pwm_load,
               rec_len, busy, done, state_dbg
    );
endinterface

// File: rtl/audio_seq_ctrl.sv
// Record/playback sequencer for the microphone-to-PWM audio path.
// Records mic samples into an external single-port RAM, then plays them back
// one sample every SAMPLE_DIV clocks as PWM duty values (once or looping).
// Ports:
//   clk_in  : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   io_bus  : audio_seq_ctrl_if master (controls, mic, RAM port, PWM, status)
//
// state  | meaning
// S_IDLE | waiting for rec_start / play_start
// S_REC  | mic enabled, each mic sample written to the next RAM address
// S_PLAY | one RAM read per SAMPLE_DIV ticks, result loaded into the PWM duty
module audio_seq_ctrl #(
    parameter int ADDR_W     = 10,
    parameter int SAMPLE_W   = 8,
    parameter int DUTY_W     = 6,
    parameter int SAMPLE_DIV = 2048
) (
    input  logic             clk_in,
    input  logic             rst_n,
    audio_seq_ctrl_if.master io_bus
);
    localparam int TICK_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
    localparam logic [ADDR_W:0]   DEPTH     = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REC  = 2'd1,
        S_PLAY = 2'd2
    } state_t;

    state_t              r_state,    w_state;
    logic [ADDR_W-1:0]   r_addr,     w_addr;
    logic [ADDR_W:0]     r_rec_len,  w_rec_len;
    logic [TICK_W-1:0]   r_tick,     w_tick;
    logic                r_mic_en,   w_mic_en;
    logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr;
    logic                r_mem_we,   w_mem_we;
    logic [SAMPLE_W-1:0] r_mem_wdata, w_mem_wdata;
    logic                r_mem_re,   w_mem_re;
    logic                r_rd_pend,  w_rd_pend;
    logic [DUTY_W-1:0]   r_pwm_duty, w_pwm_duty;
    logic                r_pwm_load, w_pwm_load;
    logic                r_done,     w_done;
    logic [TICK_W-1:0]   w_tick_nxt;
    logic                w_last_rd;
    logic                w_unused_rdata_lsb;

    // Only the duty MSBs of a sample reach the PWM.
    assign w_unused_rdata_lsb = ^io_bus.mem_rdata[SAMPLE_W-DUTY_W-1:0];

    always_comb begin
        w_state     = r_state;
        w_addr      = r_addr;
        w_rec_len   = r_rec_len;
        w_tick      = r_tick;
        w_mic_en    = r_mic_en;
        w_mem_addr  = r_mem_addr;
        w_mem_we    = 1'b0;
        w_mem_wdata = r_mem_wdata;
        w_mem_re    = 1'b0;
        w_rd_pend   = 1'b0;
        w_pwm_duty  = r_pwm_duty;
        w_pwm_load  = 1'b0;
        w_done      = 1'b0;
        w_tick_nxt  = (r_tick == TICK_LAST) ? '0 : r_tick + TICK_W'(1);
        // mem_addr still holds the in-flight read address when its data lands,
        // because the next read is at least three cycles away.
        w_last_rd   = ({1'b0, r_mem_addr} == r_rec_len - (ADDR_W+1)'(1));

        if (io_bus.stop) begin
            // Dropping rd_pend discards any read already in flight.
            w_state    = S_IDLE;
            w_mic_en   = 1'b0;
            w_pwm_duty = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (io_bus.rec_start) begin
                        w_state   = S_REC;
                        w_addr    = '0;
                        w_rec_len = '0;
                        w_mic_en  = 1'b1;
                    end else if (io_bus.play_start && (r_rec_len != '0)) begin
                        // First read is issued on entry so it lands on tick 0.
                        w_state    = S_PLAY;
                        w_tick     = '0;
                        w_mem_re   = 1'b1;
                        w_mem_addr = '0;
                        w_addr     = ADDR_W'(1);
                    end
                end
                S_REC: begin
                    // rec_len reaches DEPTH while the final write is on the bus;
                    // finish one cycle later so mem_we never shows outside REC.
                    if (r_rec_len == DEPTH) begin
                        w_state  = S_IDLE;
                        w_mic_en = 1'b0;
                        w_done   = 1'b1;
                    end else if (io_bus.mic_valid) begin
                        w_mem_we    = 1'b1;
                        w_mem_addr  = r_addr;
                        w_mem_wdata = io_bus.mic_data;
                        w_addr      = r_addr + ADDR_W'(1);
                        w_rec_len   = r_rec_len + (ADDR_W+1)'(1);
                    end
                end
                S_PLAY: begin
                    w_tick    = w_tick_nxt;
                    w_rd_pend = r_mem_re;
                    if (r_rd_pend) begin
                        w_pwm_duty = io_bus.mem_rdata[SAMPLE_W-1 -: DUTY_W];
                        w_pwm_load = 1'b1;
                        if (w_last_rd) begin
                            if (io_bus.loop_en) begin
                                w_addr = '0;
                            end else begin
                                w_state = S_IDLE;
                                w_done  = 1'b1;
                            end
                        end
                    end
                    if ((w_tick_nxt == '0) && (w_state == S_PLAY)) begin
                        w_mem_re   = 1'b1;
                        w_mem_addr = w_addr;
                        w_addr     = w_addr + ADDR_W'(1);
                    end
                end
                default: w_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_rec_len   <= '0;
            r_tick      <= '0;
            r_mic_en    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_mem_re    <= 1'b0;
            r_rd_pend   <= 1'b0;
            r_pwm_duty  <= '0;
            r_pwm_load  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_addr      <= w_addr;
            r_rec_len   <= w_rec_len;
            r_tick      <= w_tick;
            r_mic_en    <= w_mic_en;
            r_mem_addr  <= w_mem_addr;
            r_mem_we    <= w_mem_we;
            r_mem_wdata <= w_mem_wdata;
            r_mem_re    <= w_mem_re;
            r_rd_pend   <= w_rd_pend;
            r_pwm_duty  <= w_pwm_duty;
            r_pwm_load  <= w_pwm_load;
            r_done      <= w_done;
        end
    end

    assign io_bus.mic_en    = r_mic_en;
    assign io_bus.mem_addr  = r_mem_addr;
    assign io_bus.mem_we    = r_mem_we;
    assign io_bus.mem_wdata = r_mem_wdata;
    assign io_bus.mem_re    = r_mem_re;
    assign io_bus.pwm_duty  = r_pwm_duty;
    assign io_bus.pwm_load  = r_pwm_load;
    assign io_bus.rec_len   = r_rec_len;
    assign io_bus.busy      = (r_state != S_IDLE);
    assign io_bus.done      = r_done;
    assign io_bus.state_dbg = r_state;
endmodule
